// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

    // Operand width used when the top is instantiated without an override.
    localparam int DEFAULT_WIDTH = 8;

    // FSM encoding; values are fixed so waveforms decode the same across builds.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor x - y - bin, built from two half-subtract stages and an OR.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    // First half stage takes x - y; the second subtracts the incoming borrow from that partial difference.
    always_comb begin
        d1   = x ^ y;
        b1   = ~x & y;
        d    = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial unsigned subtractor: diff = a - b, borrow_out = (a < b).
// Latency: start at edge k -> busy cycles k+1..k+WIDTH, done pulse in cycle k+WIDTH+1.
// Backpressure: none; start is only honoured in IDLE, and is dropped in RUN/DONE.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Derived from WIDTH; kept local so it cannot be overridden inconsistently.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bout;

    assign last_bit = (cnt == LAST_CNT);

    // busy/done decode straight from the state register, so no input reaches them combinationally.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    full_subtractor_cell u_cell (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one pass of WIDTH bits, a single DONE cycle, then back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:                  state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Datapath: capture operands on accepted start, then process one bit per clock in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        br   <= 1'b0;
                        cnt  <= '0;
                        diff <= '0;
                    end
                end
                RUN: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= cell_bout;
                    // Result bits enter at the MSB; after WIDTH shifts bit 0 lands at diff[0].
                    diff <= {cell_d, diff[WIDTH-1:1]};
                    // Counter stops at the last bit so a stray extra RUN cycle can never wrap.
                    if (!last_bit) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        borrow_out <= cell_bout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with a scoreboard queue of expected results.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic         bo;
        logic [W-1:0] d;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    exp_t         sb_q[$];
    int           n_tests;
    int           n_fail;
    logic [W-1:0] last_diff;
    longint       done_t;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            done_t = $time;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff", {24'd0, diff}, {24'd0, e.d});
                check("borrow_out", {31'd0, borrow_out}, {31'd0, e.bo});
            end
        end
    end

    // Issue one operation; optionally re-pulse start (with other operands) in busy cycle 'inject'.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input int inject);
        int           cyc;
        int           nbusy;
        logic [W-1:0] e;
        @(negedge clk);
        check("hold_diff", {24'd0, diff}, {24'd0, last_diff});
        check("idle_busy", {31'd0, busy}, 32'd0);
        a     = av;
        b     = bv;
        start = 1'b1;
        e     = av - bv;
        sb_q.push_back({(av < bv), e});
        last_diff = e;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cyc   = 1;
        nbusy = 0;
        while (!done && cyc < 40) begin
            if (busy) nbusy++;
            if (cyc == inject) begin
                a     = 8'h00;
                b     = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_latency", cyc, W + 1);
        check("busy_cycles", nbusy, W);
    endtask

    initial begin
        longint t1;
        n_tests   = 0;
        n_fail    = 0;
        last_diff = '0;
        done_t    = 0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_borrow", {31'd0, borrow_out}, 32'd0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h23, 0);
        run_op(8'h10, 8'h20, 0);
        run_op(8'h00, 8'h01, 0);
        run_op(8'hFF, 8'h01, 0);
        run_op(8'h00, 8'h00, 0);
        // Start during busy cycle 4 must be ignored.
        run_op(8'h5A, 8'h23, 4);

        // Asynchronous reset in RUN cycle 3: outputs clear at once, op discarded.
        @(negedge clk);
        a     = 8'h77;
        b     = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_diff", {24'd0, diff}, 32'd0);
        check("arst_borrow", {31'd0, borrow_out}, 32'd0);
        last_diff = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(8'h33, 8'h44, 0);

        // Back-to-back issue through the single IDLE cycle: done pulses 10 cycles apart.
        run_op(8'hC8, 8'h64, 0);
        t1 = done_t;
        run_op(8'h01, 8'h80, 0);
        check("b2b_gap", 32'(done_t - t1), 32'd100);

        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom), 0);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
